// File: rtl/cfg_pkg.sv
// cfg_pkg: build-wide configuration for the stack subsystem.
//   ENGS_N : number of engines that share the banked stack SRAM.
package cfg_pkg;

  localparam int ENGS_N = 4;

endpackage

// File: rtl/stk_pkg.sv
// stk_pkg: shared types and geometry for the stack subsystem.
//   BANKS_N / C_BANK_LINES_N : banked stack SRAM geometry.
//   PTR_W                    : SRAM location {bnk_id, line_id}.
//   opcode_t                 : NOP / PUSH / POP / INV command opcodes.
package stk_pkg;

  localparam int BANKS_N        = 4;
  localparam int BANK_W         = $clog2(BANKS_N);
  localparam int C_BANK_LINES_N = 1024;
  localparam int LINE_W         = $clog2(C_BANK_LINES_N);
  localparam int PTR_W          = BANK_W + LINE_W;
  localparam int OPCODE_W       = 2;
  localparam int ENGID_W        = (cfg_pkg::ENGS_N > 1) ? $clog2(cfg_pkg::ENGS_N) : 1;

  typedef enum logic [OPCODE_W-1:0] {
    OPCODE_NOP  = 2'd0,
    OPCODE_PUSH = 2'd1,
    OPCODE_POP  = 2'd2,
    OPCODE_INV  = 2'd3
  } opcode_t;

  typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/stk_head_tbl_if.sv
// stk_head_tbl_if: command/response bundle of the stack head-pointer table.
//   cmd_vld/cmd_opcode/cmd_engid/cmd_rdy          : command channel (master -> slave)
//   rsp_vld/rsp_opcode/rsp_engid/rsp_ptr/rsp_err  : response channel (slave -> master)
//   rsp_rdy                                       : response back-pressure (master -> slave)
interface stk_head_tbl_if;

  logic                         cmd_vld;
  stk_pkg::opcode_t             cmd_opcode;
  logic [stk_pkg::ENGID_W-1:0]  cmd_engid;
  logic                         cmd_rdy;
  logic                         rsp_vld;
  stk_pkg::opcode_t             rsp_opcode;
  logic [stk_pkg::ENGID_W-1:0]  rsp_engid;
  stk_pkg::ptr_t                rsp_ptr;
  logic                         rsp_err;
  logic                         rsp_rdy;

  modport master (
    output cmd_vld, cmd_opcode, cmd_engid, rsp_rdy,
    input  cmd_rdy, rsp_vld, rsp_opcode, rsp_engid, rsp_ptr, rsp_err
  );

  modport slave (
    input  cmd_vld, cmd_opcode, cmd_engid, rsp_rdy,
    output cmd_rdy, rsp_vld, rsp_opcode, rsp_engid, rsp_ptr, rsp_err
  );

endinterface

// File: rtl/stk_head_tbl.sv
// stk_head_tbl: per-engine stack head-pointer responder.
// Keeps one depth counter per engine and answers every PUSH/POP with the
// SRAM location {bnk_id, line_id} the engine must write or read. INV empties
// an engine's stack; NOP is accepted silently.
// Ports:
//   clk, arst : clock and asynchronous active-high reset
//   bus       : stk_head_tbl_if.slave command/response bundle
//   empty_vec : per-engine "stack empty" flags (only with STK_HEAD_TBL_EMPTY_VEC_EN)
// Optional feature macro: STK_HEAD_TBL_EMPTY_VEC_EN adds the empty_vec output.
module stk_head_tbl #(
  parameter int ENGS_N = cfg_pkg::ENGS_N
) (
  input  logic                clk,
  input  logic                arst,
  stk_head_tbl_if.slave       bus
`ifdef STK_HEAD_TBL_EMPTY_VEC_EN
  ,
  output logic [ENGS_N-1:0]   empty_vec
`endif
);

  localparam int CAP_N         = stk_pkg::BANKS_N * stk_pkg::C_BANK_LINES_N / ENGS_N;
  localparam int CNT_W         = $clog2(CAP_N) + 1;
  localparam int LINES_PER_ENG = stk_pkg::C_BANK_LINES_N / ENGS_N;
  localparam int BANK_W        = stk_pkg::BANK_W;
  localparam int LINE_W        = stk_pkg::LINE_W;
  localparam int PTR_W         = stk_pkg::PTR_W;
  localparam int ENGID_W       = stk_pkg::ENGID_W;

  // Entry k of an engine: low bits of k rotate across banks, the rest walk
  // up through the engine's private slice of lines.
  function automatic logic [PTR_W-1:0] map_ptr(input logic [ENGID_W-1:0] eng,
                                               input logic [CNT_W-1:0]   k);
    logic [31:0] line_s;
    line_s = 32'(eng) * 32'(LINES_PER_ENG) + 32'(k >> BANK_W);
    return {k[BANK_W-1:0], line_s[LINE_W-1:0]};
  endfunction

  logic                 accept_s;
  logic                 eng_ok_s;
  logic                 rsp_gen_s;
  logic                 cnt_we_s;
  logic                 err_s;
  logic [CNT_W-1:0]     cur_cnt_s;
  logic [CNT_W-1:0]     nxt_cnt_s;
  logic [PTR_W-1:0]     ptr_s;

  logic [CNT_W-1:0]     cnt_r [ENGS_N];
  logic                 rsp_vld_r;
  stk_pkg::opcode_t     rsp_opcode_r;
  logic [ENGID_W-1:0]   rsp_engid_r;
  logic [PTR_W-1:0]     rsp_ptr_r;
  logic                 rsp_err_r;

  // The output register can take a new response when empty or being drained
  assign bus.cmd_rdy = !rsp_vld_r || bus.rsp_rdy;
  assign accept_s    = bus.cmd_vld && bus.cmd_rdy;
  assign rsp_gen_s   = (bus.cmd_opcode != stk_pkg::OPCODE_NOP);
  assign eng_ok_s    = (32'(bus.cmd_engid) < 32'(ENGS_N));

  // Current depth of the addressed engine (zero for an out-of-range ID)
  always_comb begin
    if (eng_ok_s) begin
      cur_cnt_s = cnt_r[bus.cmd_engid];
    end else begin
      cur_cnt_s = '0;
    end
  end

  // Decode the command against the engine's depth: pointer, error and next depth
  always_comb begin
    nxt_cnt_s = cur_cnt_s;
    cnt_we_s  = 1'b0;
    err_s     = 1'b0;
    ptr_s     = '0;
    case (bus.cmd_opcode)
      stk_pkg::OPCODE_PUSH: begin
        if (!eng_ok_s) begin
          err_s = 1'b1;
        end else if (cur_cnt_s < CNT_W'(CAP_N)) begin
          ptr_s     = map_ptr(bus.cmd_engid, cur_cnt_s);
          nxt_cnt_s = cur_cnt_s + CNT_W'(1'b1);
          cnt_we_s  = 1'b1;
        end else begin
          err_s = 1'b1;
        end
      end
      stk_pkg::OPCODE_POP: begin
        if (!eng_ok_s) begin
          err_s = 1'b1;
        end else if (cur_cnt_s != '0) begin
          ptr_s     = map_ptr(bus.cmd_engid, cur_cnt_s - CNT_W'(1'b1));
          nxt_cnt_s = cur_cnt_s - CNT_W'(1'b1);
          cnt_we_s  = 1'b1;
        end else begin
          err_s = 1'b1;
        end
      end
      stk_pkg::OPCODE_INV: begin
        if (eng_ok_s) begin
          nxt_cnt_s = '0;
          cnt_we_s  = 1'b1;
        end else begin
          err_s = 1'b1;
        end
      end
      default: begin
        nxt_cnt_s = cur_cnt_s;
      end
    endcase
  end

  // Per-engine depth counters; only the addressed engine is ever written
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < ENGS_N; i++) begin
        cnt_r[i] <= '0;
      end
    end else if (accept_s && cnt_we_s) begin
      cnt_r[bus.cmd_engid] <= nxt_cnt_s;
    end
  end

  // Single response register: loads on accepted PUSH/POP/INV, empties when drained
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rsp_vld_r    <= 1'b0;
      rsp_opcode_r <= stk_pkg::OPCODE_NOP;
      rsp_engid_r  <= '0;
      rsp_ptr_r    <= '0;
      rsp_err_r    <= 1'b0;
    end else if (bus.cmd_rdy) begin
      if (accept_s && rsp_gen_s) begin
        rsp_vld_r    <= 1'b1;
        rsp_opcode_r <= bus.cmd_opcode;
        rsp_engid_r  <= bus.cmd_engid;
        rsp_ptr_r    <= ptr_s;
        rsp_err_r    <= err_s;
      end else begin
        rsp_vld_r <= 1'b0;
      end
    end
  end

  assign bus.rsp_vld    = rsp_vld_r;
  assign bus.rsp_opcode = rsp_opcode_r;
  assign bus.rsp_engid  = rsp_engid_r;
  assign bus.rsp_ptr    = rsp_ptr_r;
  assign bus.rsp_err    = rsp_err_r;

`ifdef STK_HEAD_TBL_EMPTY_VEC_EN
  logic [ENGS_N-1:0] empty_vec_r;

  // Empty flags track the counters after each accepted command
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      empty_vec_r <= '1;
    end else if (accept_s && cnt_we_s) begin
      empty_vec_r[bus.cmd_engid] <= (nxt_cnt_s == '0);
    end
  end

  assign empty_vec = empty_vec_r;
`endif

endmodule

// File: tb/tb_stk_head_tbl.sv
// tb_stk_head_tbl: self-checking bench for stk_head_tbl (ENGS_N = 4, CAP_N = 1024).
// A depth-per-engine reference model predicts every response; a negedge
// monitor compares the DUT against it, and directed sequences pin literal values.
module tb_stk_head_tbl;

  typedef struct packed {
    logic [1:0]  op;
    logic [1:0]  eng;
    logic [11:0] ptr;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic arst;

  stk_head_tbl_if bus ();

`ifdef STK_HEAD_TBL_EMPTY_VEC_EN
  logic [3:0] empty_vec;
  stk_head_tbl dut (.clk(clk), .arst(arst), .bus(bus.slave), .empty_vec(empty_vec));
`else
  stk_head_tbl dut (.clk(clk), .arst(arst), .bus(bus.slave));
`endif

  always #5 clk = ~clk;

  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   depth [4];
  rsp_t exp_q [$];
  rsp_t got_q [$];
  bit   rnd_en   = 1'b0;
  bit   hold_prev = 1'b0;
  logic [16:0] prev_snap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    chk_cnt++;
    $display("FAIL %s: timed out waiting, got no event expected one", name);
  endtask

  // Reference location of entry k for engine eng: bank = k mod 4, line = eng*256 + k/4
  function automatic logic [11:0] ref_ptr(input int eng, input int k);
    return 12'((k % 4) * 1024 + eng * 256 + k / 4);
  endfunction

  function automatic rsp_t model_step(input logic [1:0] op, input logic [1:0] eng);
    rsp_t r;
    r.op = op; r.eng = eng; r.ptr = 12'd0; r.err = 1'b0;
    case (op)
      2'd1: if (depth[eng] < 1024) begin r.ptr = ref_ptr(eng, depth[eng]); depth[eng]++; end
            else r.err = 1'b1;
      2'd2: if (depth[eng] > 0) begin depth[eng]--; r.ptr = ref_ptr(eng, depth[eng]); end
            else r.err = 1'b1;
      2'd3: depth[eng] = 0;
      default: r.err = 1'b0;
    endcase
    return r;
  endfunction

  // Negedge monitor: checks the response channel against the model every cycle
  always @(negedge clk) begin
    logic [16:0] snap;
    rsp_t e, a;
    if (arst) begin
      hold_prev = 1'b0;
    end else begin
      snap = {bus.rsp_opcode, bus.rsp_engid, bus.rsp_ptr, bus.rsp_err};
      chk("rsp_vld", 32'(bus.rsp_vld), 32'(exp_q.size() != 0));
      chk("cmd_rdy", 32'(bus.cmd_rdy), 32'(!bus.rsp_vld || bus.rsp_rdy));
      if (hold_prev) chk("rsp_stable", 32'(snap), 32'(prev_snap));
      if (bus.rsp_vld && exp_q.size() != 0) begin
        e = exp_q[0];
        a = {bus.rsp_opcode, bus.rsp_engid, bus.rsp_ptr, bus.rsp_err};
        chk("rsp_fields", 32'(a), 32'(e));
        if (bus.rsp_rdy) begin
          got_q.push_back(a);
          void'(exp_q.pop_front());
        end
      end
      hold_prev = bus.rsp_vld && !bus.rsp_rdy;
      prev_snap = snap;
      if (bus.cmd_vld && bus.cmd_rdy && bus.cmd_opcode != stk_pkg::OPCODE_NOP)
        exp_q.push_back(model_step(bus.cmd_opcode, bus.cmd_engid));
    end
  end

  // Random back-pressure during the random phase
  always begin
    @(posedge clk); #1;
    if (rnd_en) bus.rsp_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input stk_pkg::opcode_t op, input logic [1:0] eng);
    bit acc = 1'b0;
    bus.cmd_vld = 1'b1; bus.cmd_opcode = op; bus.cmd_engid = eng;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (bus.cmd_rdy) begin acc = 1'b1; break; end
    end
    if (!acc) timeout("send_accept");
    @(posedge clk); #1;
    bus.cmd_vld = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.rsp_vld) begin idle = 1'b1; break; end
    end
    if (!idle) timeout("drain");
    @(posedge clk); #1;
  endtask

  task automatic chk_got(input string name, input int idx, input logic [11:0] ptr, input logic err);
    if (idx >= got_q.size()) begin
      timeout(name);
    end else begin
      chk({name, "_ptr"}, 32'(got_q[idx].ptr), 32'(ptr));
      chk({name, "_err"}, 32'(got_q[idx].err), 32'(err));
    end
  endtask

  initial begin
    int r;
    arst = 1'b1;
    bus.cmd_vld = 1'b0; bus.cmd_opcode = stk_pkg::OPCODE_NOP; bus.cmd_engid = 2'd0;
    bus.rsp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) depth[i] = 0;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    chk("reset_rsp_opcode", 32'(bus.rsp_opcode), 32'd0);
    chk("reset_rsp_engid", 32'(bus.rsp_engid), 32'd0);
    chk("reset_rsp_ptr", 32'(bus.rsp_ptr), 32'd0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
`ifdef STK_HEAD_TBL_EMPTY_VEC_EN
    chk("reset_empty_vec", 32'(empty_vec), 32'hF);
`endif
    @(posedge clk); #1;

    // eng1 push/pop sequence including underflow
    got_q.delete();
    send(stk_pkg::OPCODE_PUSH, 2'd1);
    send(stk_pkg::OPCODE_PUSH, 2'd1);
    send(stk_pkg::OPCODE_POP, 2'd1);
    send(stk_pkg::OPCODE_POP, 2'd1);
    send(stk_pkg::OPCODE_POP, 2'd1);
    wait_idle();
    chk_got("e1_push0", 0, 12'h100, 1'b0);
    chk_got("e1_push1", 1, 12'h500, 1'b0);
    chk_got("e1_pop0", 2, 12'h500, 1'b0);
    chk_got("e1_pop1", 3, 12'h100, 1'b0);
    chk_got("e1_underflow", 4, 12'h000, 1'b1);

    // eng3 fill to capacity, overflow, INV then PUSH
    got_q.delete();
    for (int i = 0; i < 1025; i++) send(stk_pkg::OPCODE_PUSH, 2'd3);
    wait_idle();
    chk_got("e3_last", 1023, 12'hFFF, 1'b0);
    chk_got("e3_overflow", 1024, 12'h000, 1'b1);
    chk("e3_depth_model", 32'(depth[3]), 32'd1024);
    got_q.delete();
    send(stk_pkg::OPCODE_INV, 2'd3);
    send(stk_pkg::OPCODE_PUSH, 2'd3);
    wait_idle();
    chk_got("e3_inv", 0, 12'h000, 1'b0);
    chk_got("e3_after_inv", 1, 12'h300, 1'b0);

    // Back-pressure: response held for 5 cycles with a command waiting
    got_q.delete();
    bus.rsp_rdy = 1'b0;
    bus.cmd_vld = 1'b1; bus.cmd_opcode = stk_pkg::OPCODE_PUSH; bus.cmd_engid = 2'd0;
    @(negedge clk);
    chk("stall_first_accept", 32'(bus.cmd_rdy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
      chk("stall_ptr", 32'(bus.rsp_ptr), 32'h000);
    end
    @(posedge clk); #1;
    bus.rsp_rdy = 1'b1;
    send(stk_pkg::OPCODE_PUSH, 2'd0);
    send(stk_pkg::OPCODE_PUSH, 2'd0);
    wait_idle();
    chk_got("stall_r0", 0, 12'h000, 1'b0);
    chk_got("stall_r1", 1, 12'h400, 1'b0);
    chk_got("stall_r2", 2, 12'h800, 1'b0);

    // Interleaved eng0/eng2 pushes
    send(stk_pkg::OPCODE_INV, 2'd0);
    wait_idle();
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      send(stk_pkg::OPCODE_PUSH, 2'd0);
      send(stk_pkg::OPCODE_PUSH, 2'd2);
    end
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      chk_got("il_eng0", 2 * i, 12'(i * 1024), 1'b0);
      chk_got("il_eng2", 2 * i + 1, 12'(i * 1024 + 512), 1'b0);
    end

    // Random traffic with random back-pressure
    rnd_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      send((r == 0) ? stk_pkg::OPCODE_NOP : (r <= 5) ? stk_pkg::OPCODE_PUSH :
           (r <= 8) ? stk_pkg::OPCODE_POP : stk_pkg::OPCODE_INV,
           2'($urandom_range(0, 3)));
    end
    rnd_en = 1'b0;
    @(posedge clk); #1;
    bus.rsp_rdy = 1'b1;
    wait_idle();

    // Reset while a response is pending and eng0 holds 3 entries
    send(stk_pkg::OPCODE_INV, 2'd0);
    send(stk_pkg::OPCODE_PUSH, 2'd0);
    send(stk_pkg::OPCODE_PUSH, 2'd0);
    wait_idle();
    bus.rsp_rdy = 1'b0;
    send(stk_pkg::OPCODE_PUSH, 2'd0);
    chk("pre_arst_vld", 32'(bus.rsp_vld), 32'd1);
    #2 arst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) depth[i] = 0;
    #1 chk("arst_async_vld", 32'(bus.rsp_vld), 32'd0);
`ifdef STK_HEAD_TBL_EMPTY_VEC_EN
    chk("arst_empty_vec", 32'(empty_vec), 32'hF);
`endif
    bus.rsp_rdy = 1'b1;
    @(posedge clk); #1 arst = 1'b0;
    got_q.delete();
    send(stk_pkg::OPCODE_POP, 2'd0);
    wait_idle();
    chk_got("post_arst_pop", 0, 12'h000, 1'b1);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/stk_head_tbl.md
# stk_head_tbl

- Per-engine stack head-pointer responder for the stack subsystem.
- Accepts `stk_pkg::opcode_t` commands tagged with an engine ID and maintains a depth counter for each engine.
- Answers each PUSH/POP with the `stk_pkg::ptr_t` location the engine must write or read.
- Sits between the engine command issue path and the banked stack SRAM, and is the responder for the opcode protocol.

## Interface
Parameters:
- `ENGS_N`, default `cfg_pkg::ENGS_N` (4): engine count. Power of two, 1..1024.
- `CAP_N`, derived, = `stk_pkg::BANKS_N*stk_pkg::C_BANK_LINES_N/ENGS_N`: entries per engine (1024 at the default).
- `CNT_W`, derived, = `$clog2(CAP_N)+1`: depth counter width.

Ports:
- `clk`  in  1  clock; single clock domain.
- `arst`  in  1  reset; asynchronous, active-high.
- `cmd_vld`  in  1  command valid.
- `cmd_opcode`  in  `stk_pkg::OPCODE_W`  NOP/PUSH/POP/INV.
- `cmd_engid`  in  `stk_pkg::ENGID_W`  target engine.
- `cmd_rdy`  out  1  command accepted when `cmd_vld & cmd_rdy`.
- `rsp_vld`  out  1  response valid (registered).
- `rsp_opcode`  out  `OPCODE_W`  echo of the accepted opcode.
- `rsp_engid`  out  `ENGID_W`  echo of the accepted engine ID.
- `rsp_ptr`  out  `stk_pkg::PTR_W`  SRAM location `{bnk_id, line_id}`.
- `rsp_err`  out  1  overflow or underflow.
- `rsp_rdy`  in  1  downstream accepts the response.

## Operation
- State: `cnt[ENGS_N]` registers, each `CNT_W` bits, holding the engine's depth. Range 0..CAP_N.
- Entry index k maps to SRAM as follows:
  - `bnk_id = k[BANK_W-1:0]`: consecutive entries rotate across banks.
  - `line_id = engid*(C_BANK_LINES_N/ENGS_N) + (k >> BANK_W)`.
- PUSH:
  - If `cnt < CAP_N`: `rsp_ptr = map(cnt)`, `rsp_err = 0`, then `cnt++`.
  - Else (full): `rsp_err = 1`, `rsp_ptr = 0`, `cnt` unchanged.
- POP:
  - If `cnt > 0`: `rsp_ptr = map(cnt-1)`, `rsp_err = 0`, then `cnt--`.
  - Else (empty): `rsp_err = 1`, `rsp_ptr = 0`, `cnt` unchanged.
- INV: `cnt = 0` for that engine; `rsp_err = 0`, `rsp_ptr = 0`. A response is produced.
- NOP: accepted, no state change, no response (`rsp_vld` does not assert for it).
- Each engine is fully independent; other engines' counters are never touched.

## Timing
- Reset values:
  - All `cnt = 0`.
  - `rsp_vld = 0`, `rsp_opcode = OPCODE_NOP`, `rsp_engid = 0`, `rsp_ptr = 0`, `rsp_err = 0`.
  - `cmd_rdy` is 1 out of reset.
- `cmd_rdy = !rsp_vld | rsp_rdy` (combinational from `rsp_rdy`). This is a single output register with no extra buffering.
- Latency: a command accepted in cycle N produces `rsp_*` valid in cycle N+1. The counter update is visible to a command accepted in N+1, so back-to-back commands to the same engine are full throughput with no bubble.
- Responses are held stable while `rsp_vld & !rsp_rdy`.
- Response order equals acceptance order.
- An accepted NOP while `rsp_rdy = 1` clears `rsp_vld` in the next cycle.
- `arst` mid-operation:
  - Any pending response is dropped.
  - All stacks empty; `rsp_vld` deasserts asynchronously.
- INV followed immediately by PUSH to the same engine: the PUSH returns `map(0)`.
- Command with `cmd_engid >= ENGS_N` (non-power-of-two builds only): `rsp_err = 1`, no state change.

## Configuration
- `STK_HEAD_TBL_EMPTY_VEC_EN`:
  - Defined: adds output `empty_vec  out  ENGS_N`, where bit i is `cnt[i] == 0`. It is registered and reflects the counters after the last accepted command; reset value all ones.
  - Undefined: the port and its logic are absent; behaviour is otherwise identical.

## Test plan
Default `ENGS_N = 4`, so `CAP_N = 1024`.
- Reset, then PUSH eng1 twice -> responses in N+1, N+2:
  - `ptr = {0, 256}`, err 0.
  - `ptr = {1, 256}`, err 0.
- Then POP eng1 -> `ptr = {1, 256}`; POP eng1 -> `{0, 256}`; POP eng1 -> err 1, ptr 0.
- PUSH eng3 1024 times -> last `ptr = {3, 1023}`. The 1025th PUSH -> err 1 and `cnt` stays 1024. INV eng3 then PUSH eng3 -> `ptr = {0, 768}`.
- Hold `rsp_rdy = 0` for 5 cycles with `cmd_vld` high:
  - `cmd_rdy = 0` after the first accept, and `rsp_*` is stable.
  - Release `rsp_rdy` -> commands resume one per cycle, in order.
- Interleave PUSH eng0/eng2 alternately 4 times -> eng0 ptrs `{0..3, 0}`, eng2 ptrs `{0..3, 512}`. No cross-engine effect.
- Assert `arst` while `rsp_vld = 1` with eng0 depth 3:
  - `rsp_vld = 0` immediately.
  - A subsequent POP eng0 -> err 1.
  - With `STK_HEAD_TBL_EMPTY_VEC_EN` defined, `empty_vec = 4'b1111`.
